// File: rtl/ic_74595.sv
// 74x595-style serial-in shift register with storage register; pins are synchronised into clk.
// Latency: pin edge to output change is SYNC_STAGES+2 clk cycles; no backpressure.
module ic_74595 #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser,
    input  logic             srclk,
    input  logic             srclr_n,
    input  logic             rclk,
    input  logic             oe_n,
    output logic [WIDTH-1:0] q,
    output logic             q_en,
    output logic             qh_prime
);

    localparam int P_SER   = 4;
    localparam int P_SRCLK = 3;
    localparam int P_CLR_N = 2;
    localparam int P_RCLK  = 1;
    localparam int P_OE_N  = 0;
    localparam logic [4:0] PIN_IDLE = 5'b00101;

    logic [4:0] pins;
    logic [4:0] sync_q [SYNC_STAGES];
    logic [4:0] pin_s;
    logic [SYNC_STAGES:0] arm_q;
    logic       armed;
    logic       srclk_prev_q, rclk_prev_q;
    logic       srclk_stb_q, rclk_stb_q, ser_q, clr_q, oe_q;

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] storage_q, storage_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_en_q, q_en_d;
    logic             qh_q, qh_d;

    assign pins  = {ser, srclk, srclr_n, rclk, oe_n};
    assign pin_s = sync_q[SYNC_STAGES-1];
    assign armed = arm_q[SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_IDLE;
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Edges are suppressed until the chain and the previous-value flops hold real
    // pin samples, so a pin already high at reset release is not seen as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q        <= '0;
            srclk_prev_q <= 1'b0;
            rclk_prev_q  <= 1'b0;
            srclk_stb_q  <= 1'b0;
            rclk_stb_q   <= 1'b0;
            ser_q        <= 1'b0;
            clr_q        <= 1'b0;
            oe_q         <= 1'b0;
        end else begin
            arm_q        <= {arm_q[SYNC_STAGES-1:0], 1'b1};
            srclk_prev_q <= pin_s[P_SRCLK];
            rclk_prev_q  <= pin_s[P_RCLK];
            srclk_stb_q  <= armed & pin_s[P_SRCLK] & ~srclk_prev_q;
            rclk_stb_q   <= armed & pin_s[P_RCLK] & ~rclk_prev_q;
            ser_q        <= pin_s[P_SER];
            clr_q        <= ~pin_s[P_CLR_N];
            oe_q         <= ~pin_s[P_OE_N];
        end
    end

    // Storage samples the pre-shift contents, giving the one-stage lag of the 74x595.
    always_comb begin
        shift_d   = shift_q;
        storage_d = storage_q;
        if (clr_q)
            shift_d = '0;
        else if (srclk_stb_q)
            shift_d = {shift_q[WIDTH-2:0], ser_q};
        if (rclk_stb_q)
            storage_d = shift_q;
        q_en_d = oe_q;
        q_d    = q_en_d ? storage_d : '0;
        qh_d   = shift_d[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            storage_q <= '0;
            q_q       <= '0;
            q_en_q    <= 1'b0;
            qh_q      <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            storage_q <= storage_d;
            q_q       <= q_d;
            q_en_q    <= q_en_d;
            qh_q      <= qh_d;
        end
    end

    assign q        = q_q;
    assign q_en     = q_en_q;
    assign qh_prime = qh_q;

endmodule

// File: tb/tb_ic_74595.sv
// Bench for ic_74595: two cascaded parts checked against a 2*WIDTH-bit chain model.
module tb_ic_74595;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ser = 1'b0, srclk = 1'b0, srclr_n = 1'b1, rclk = 1'b0, oe_n = 1'b1;
    logic [W-1:0] q_a, q_b;
    logic q_en_a, q_en_b, qh_a, qh_b;

    always #5 clk = ~clk;

    ic_74595 #(.WIDTH(W), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .ser(ser), .srclk(srclk), .srclr_n(srclr_n),
        .rclk(rclk), .oe_n(oe_n), .q(q_a), .q_en(q_en_a), .qh_prime(qh_a));

    ic_74595 #(.WIDTH(W), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .ser(qh_a), .srclk(srclk), .srclr_n(srclr_n),
        .rclk(rclk), .oe_n(oe_n), .q(q_b), .q_en(q_en_b), .qh_prime(qh_b));

    // Reference: the cascade is one 2W-bit shift chain; B holds the upper half.
    logic [2*W-1:0] m_chain = '0;
    logic [2*W-1:0] m_stor  = '0;
    bit             m_en    = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [W-1:0] ea, eb;
        ea = m_en ? m_stor[W-1:0] : '0;
        eb = m_en ? m_stor[2*W-1:W] : '0;
        check({tag, ".qa"},   32'(q_a),    32'(ea));
        check({tag, ".qb"},   32'(q_b),    32'(eb));
        check({tag, ".qen"},  32'(q_en_a), 32'(m_en));
        check({tag, ".qenb"}, 32'(q_en_b), 32'(m_en));
        check({tag, ".qha"},  32'(qh_a),   32'(m_chain[W-1]));
        check({tag, ".qhb"},  32'(qh_b),   32'(m_chain[2*W-1]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".qa"},  32'(q_a),    32'h0);
        check({tag, ".qb"},  32'(q_b),    32'h0);
        check({tag, ".qen"}, 32'(q_en_a), 32'h0);
        check({tag, ".qha"}, 32'(qh_a),   32'h0);
        check({tag, ".qhb"}, 32'(qh_b),   32'h0);
    endtask

    task automatic op_pulse(input bit s, input bit r, input bit v);
        ser = v;
        tick(1);
        srclk = s;
        rclk  = r;
        tick(3);
        srclk = 1'b0;
        rclk  = 1'b0;
        tick(8);
        if (r) m_stor = m_chain;
        if (s) m_chain = {m_chain[2*W-2:0], v};
    endtask

    task automatic op_clear();
        srclr_n = 1'b0;
        ser     = 1'b1;
        tick(1);
        srclk = 1'b1;
        tick(2);
        srclk   = 1'b0;
        srclr_n = 1'b1;
        tick(8);
        m_chain = '0;
    endtask

    task automatic op_oe(input bit v);
        oe_n = v;
        tick(8);
        m_en = !v;
    endtask

    task automatic shift_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) op_pulse(1'b1, 1'b0, b[i]);
    endtask

    initial begin
        logic [W-1:0] old_q;

        // Reset with pins toggling, then release while srclk is held high
        for (int i = 0; i < 6; i++) begin
            {ser, srclk, srclr_n, rclk, oe_n} = 5'($urandom_range(0, 31));
            tick(2);
            check_zero("rst_hold");
        end
        srclr_n = 1'b1; rclk = 1'b0; ser = 1'b1; srclk = 1'b1; oe_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(8);
        srclk = 1'b0;
        tick(4);
        m_en = 1'b1;
        op_pulse(1'b0, 1'b1, 1'b0);
        check("rst_no_shift", 32'(q_a), 32'h0);
        check_model("rst_rel");

        // Shift 0xA5 then store, with exact latency of the store
        shift_byte(8'hA5);
        old_q = q_a;
        rclk = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            check($sformatf("store_lat%0d", k), 32'(q_a), (k < 4) ? 32'(old_q) : 32'hA5);
        end
        tick(2);
        rclk = 1'b0;
        tick(6);
        m_stor = m_chain;
        check_model("store");

        // Simultaneous srclk and rclk: storage gets the pre-shift value
        op_pulse(1'b1, 1'b1, 1'b0);
        check("sim_q", 32'(q_a), 32'hA5);
        check("sim_qh", 32'(qh_a), 32'h0);
        op_pulse(1'b0, 1'b1, 1'b0);
        check("sim_shift", 32'(q_a), 32'h4A);
        check_model("sim");

        // Clear overrides a concurrent shift and leaves storage alone
        shift_byte(8'hFF);
        op_pulse(1'b0, 1'b1, 1'b0);
        check("clr_pre", 32'(q_a), 32'hFF);
        op_clear();
        check("clr_stor", 32'(q_a), 32'hFF);
        op_pulse(1'b0, 1'b1, 1'b0);
        check("clr_post", 32'(q_a), 32'h00);
        check_model("clr");

        // Output enable toggling, with exact latency
        shift_byte(8'h3C);
        op_pulse(1'b0, 1'b1, 1'b0);
        check("oe_on", 32'(q_a), 32'h3C);
        for (int t = 0; t < 2; t++) begin
            oe_n = (t == 0);
            for (int k = 1; k <= 4; k++) begin
                tick(1);
                check($sformatf("oe%0d_q_lat%0d", t, k), 32'(q_a),
                      ((k < 4) == (t == 0)) ? 32'h3C : 32'h0);
                check($sformatf("oe%0d_en_lat%0d", t, k), 32'(q_en_a),
                      ((k < 4) == (t == 0)) ? 32'h1 : 32'h0);
            end
            tick(4);
        end
        check_model("oe");

        // Cascade of 16 bits, then reset in the middle of a shift
        shift_byte(8'hBE);
        shift_byte(8'hEF);
        op_pulse(1'b0, 1'b1, 1'b0);
        check("casc_qb", 32'(q_b), 32'hBE);
        check("casc_qa", 32'(q_a), 32'hEF);
        check_model("casc");
        ser = 1'b1;
        tick(1);
        srclk = 1'b1;
        tick(1);
        rst_n = 1'b0;
        tick(1);
        check_zero("casc_rst");
        srclk = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(8);
        m_chain = '0;
        m_stor  = '0;
        m_en    = 1'b1;
        check_model("casc_rel");

        // Randomised operation mix against the chain model
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0, 1: op_pulse(1'b1, 1'b0, 1'($urandom_range(0, 1)));
                2:    op_pulse(1'b0, 1'b1, 1'b0);
                3:    op_pulse(1'b1, 1'b1, 1'($urandom_range(0, 1)));
                4:    op_clear();
                default: op_oe(1'($urandom_range(0, 1)));
            endcase
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
